// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator: MSB-first 2-bit-per-clock unsigned magnitude compare with start/done handshake
module serial_mag_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             L,
    output logic             E,
    output logic             G
);
    localparam int N  = WIDTH / 2;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] sa, sb;
    logic [CW-1:0]    cnt;
    logic [1:0]       ta, tb;
    assign ta = sa[WIDTH-1 -: 2];
    assign tb = sb[WIDTH-1 -: 2];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            {L, E, G} <= 3'b000;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        cnt   <= CW'(N - 1);
                        busy  <= 1'b1;
                        {L, E, G} <= 3'b000;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // any unequal slice, or the last equal one, ends the walk
                    if (ta != tb || cnt == '0) begin
                        L     <= ta < tb;
                        E     <= ta == tb;
                        G     <= ta > tb;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        sa  <= sa << 2;
                        sb  <= sb << 2;
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_mag_comparator.sv
// tb_serial_mag_comparator: table vectors, handshake corner sequences and random compares against a model
module tb_serial_mag_comparator;
    localparam int W = 8;
    localparam int N = W / 2;
    logic clk = 0, rst = 1, start = 0;
    logic [W-1:0] a = '0, b = '0;
    logic busy, done, L, E, G;
    int passed = 0, total = 0;

    serial_mag_comparator #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .L(L), .E(E), .G(G)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   leg;
        int           lat;
    } vec_t;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Result from plain unsigned comparison; latency from the highest differing bit
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [2:0] leg, output int lat);
        logic [W-1:0] d;
        bit found;
        leg = x < y ? 3'b100 : x == y ? 3'b010 : 3'b001;
        d = x ^ y;
        lat = N;
        found = 0;
        for (int p = W - 1; p >= 0; p--)
            if (!found && d[p]) begin
                lat = (W - 1 - p) / 2 + 1;
                found = 1;
            end
    endfunction

    task automatic run_compare(input logic [W-1:0] xa, input logic [W-1:0] xb,
                               input logic [2:0] eleg, input int elat, input string nm);
        int lat, bcnt;
        bit got;
        logic [2:0] leg;
        @(negedge clk);
        a = xa; b = xb; start = 1;
        @(posedge clk);
        #1 start = 0;
        bcnt = int'(busy);
        lat = 0;
        got = 0;
        while (!got && lat < 12) begin
            @(posedge clk);
            #1 lat++;
            if (done) got = 1;
            else bcnt += int'(busy);
        end
        leg = {L, E, G};
        check({nm, " latency"}, lat, elat);
        check({nm, " busy cycles"}, bcnt, elat);
        check({nm, " LEG"}, int'(leg), int'(eleg));
        check({nm, " busy at done"}, int'(busy), 0);
        @(posedge clk);
        #1 check({nm, " done one cycle"}, int'(done), 0);
        check({nm, " LEG held"}, int'({L, E, G}), int'(eleg));
    endtask

    initial begin
        vec_t tbl[8];
        logic [2:0] mleg;
        int mlat;
        bit seen;
        tbl[0] = '{8'hA5, 8'hA5, 3'b010, 4};
        tbl[1] = '{8'h80, 8'h7F, 3'b001, 1};
        tbl[2] = '{8'h12, 8'h13, 3'b100, 4};
        tbl[3] = '{8'h00, 8'h00, 3'b010, 4};
        tbl[4] = '{8'hFF, 8'h00, 3'b001, 1};
        tbl[5] = '{8'h00, 8'hFF, 3'b100, 1};
        tbl[6] = '{8'h0C, 8'h08, 3'b001, 3};
        tbl[7] = '{8'hFF, 8'hFF, 3'b010, 4};

        #1 check("reset outputs", int'({busy, done, L, E, G}), 0);
        @(negedge clk) rst = 0;

        for (int i = 0; i < 8; i++)
            run_compare(tbl[i].a, tbl[i].b, tbl[i].leg, tbl[i].lat, $sformatf("vec%0d", i));

        // start pulsed during busy must be ignored
        @(negedge clk);
        a = 8'h40; b = 8'h30; start = 1;
        @(posedge clk);
        #1 a = 8'h00;
        @(posedge clk);
        #1 start = 0;
        check("ignore done", int'(done), 1);
        check("ignore LEG", int'({L, E, G}), 3'b001);
        @(posedge clk);
        #1 check("ignore no restart", int'({busy, done}), 0);

        // asynchronous reset mid-RUN
        @(negedge clk);
        a = 8'hA5; b = 8'hA5; start = 1;
        @(posedge clk);
        #1 start = 0;
        @(posedge clk);
        #3 rst = 1;
        #1 check("async rst outputs", int'({busy, done, L, E, G}), 0);
        #2 rst = 0;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1 if (done) seen = 1;
        end
        check("no done after rst", int'(seen), 0);

        // start held through done: re-accepted in the DONE cycle
        @(negedge clk);
        a = 8'h80; b = 8'h7F; start = 1;
        @(posedge clk);
        #1 a = 8'h01; b = 8'h02;
        @(posedge clk);
        #1 check("held first done", int'(done), 1);
        check("held first G", int'({L, E, G}), 3'b001);
        @(posedge clk);
        #1 start = 0;
        check("held reaccept busy", int'({busy, done}), 2'b10);
        check("held LEG cleared", int'({L, E, G}), 0);
        seen = 0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(posedge clk);
            #1 if (done) begin
                seen = 1;
                check("held second lat", k + 1, 4);
            end
        end
        check("held second done", int'(seen), 1);
        check("held second L", int'({L, E, G}), 3'b100);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = (i % 3 == 0) ? ra ^ W'(1 << $urandom_range(W - 1)) : W'($urandom);
            model(ra, rb, mleg, mlat);
            run_compare(ra, rb, mleg, mlat, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
